// File: rtl/io_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_uart_tx : LSU-mapped UART transmitter (FIFO + 8N1 serializer)
// Optional even parity bit when UART_TX_PARITY_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
module io_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_7030,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic        i_lsu_rden,
  output logic [31:0] o_ld_data,
  output logic        o_sel,
  output logic        o_uart_tx,
  output logic        o_tx_busy
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wptr, r_rptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_overflow;
  logic [15:0]        r_div;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [2:0]  r_bit_idx, w_bit_idx_nxt;
`ifdef UART_TX_PARITY_EN
  logic        r_parity, w_parity_nxt;
`endif

  logic        w_empty, w_full, w_pop, w_tx;
  logic        w_push_req, w_push_ok, w_wr_status, w_wr_div;
  logic        w_bit_end;
  logic [15:0] w_reload;
  logic [7:0]  w_head;
  logic [31:0] w_status;
  logic        w_unused;

  assign o_sel       = (i_lsu_addr[31:4] == BASE_ADDR[31:4]);
  assign w_push_req  = o_sel && i_lsu_wren && (i_lsu_addr[3:2] == 2'd0);
  assign w_wr_status = o_sel && i_lsu_wren && (i_lsu_addr[3:2] == 2'd1);
  assign w_wr_div    = o_sel && i_lsu_wren && (i_lsu_addr[3:2] == 2'd2);

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_cnt_w'(FIFO_DEPTH));
  // A full FIFO still takes a byte when the serializer frees a slot this cycle
  assign w_push_ok = w_push_req && (!w_full || w_pop);
  assign w_head    = r_mem[r_rptr];
  assign w_bit_end = (r_bit_cnt == 16'd0);
  assign w_reload  = r_div - 16'd1;

  assign o_tx_busy = (r_state != ST_IDLE);
  assign o_uart_tx = w_tx;

  assign w_status = (32'(r_count) << 8) |
                    {28'd0, r_overflow, o_tx_busy, w_empty, w_full};

  always_comb begin
    o_ld_data = 32'd0;
    if (o_sel && i_lsu_rden) begin
      case (i_lsu_addr[3:2])
        2'd1:    o_ld_data = w_status;
        2'd2:    o_ld_data = {16'd0, r_div};
        default: o_ld_data = 32'd0;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt  = r_parity;
`endif
    w_pop         = 1'b0;
    w_tx          = 1'b1;
    if (!w_bit_end) w_bit_cnt_nxt = r_bit_cnt - 16'd1;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_head;
          w_bit_cnt_nxt = w_reload;
`ifdef UART_TX_PARITY_EN
          w_parity_nxt  = ^w_head;
`endif
          w_state_nxt   = ST_START;
        end
      end
      ST_START: begin
        w_tx = 1'b0;
        if (w_bit_end) begin
          w_bit_cnt_nxt = w_reload;
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = ST_DATA;
        end
      end
      ST_DATA: begin
        w_tx = r_shift[0];
        if (w_bit_end) begin
          w_bit_cnt_nxt = w_reload;
          w_shift_nxt   = {1'b0, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        w_tx = r_parity;
        if (w_bit_end) begin
          w_bit_cnt_nxt = w_reload;
          w_state_nxt   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          // Chain straight into the next start bit when more data is queued
          if (!w_empty) begin
            w_pop         = 1'b1;
            w_shift_nxt   = w_head;
            w_bit_cnt_nxt = w_reload;
`ifdef UART_TX_PARITY_EN
            w_parity_nxt  = ^w_head;
`endif
            w_state_nxt   = ST_START;
          end else begin
            w_state_nxt   = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 16'd0;
      r_shift    <= 8'd0;
      r_bit_idx  <= 3'd0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_div      <= DIV_RESET;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
      if (w_push_ok) r_wptr <= r_wptr + c_ptr_w'(1);
      if (w_pop)     r_rptr <= r_rptr + c_ptr_w'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      // A dropped byte outranks a clearing write in the same cycle
      if (w_push_req && !w_push_ok)
        r_overflow <= 1'b1;
      else if (w_wr_status && i_st_data[3])
        r_overflow <= 1'b0;
      if (w_wr_div)
        r_div <= (i_st_data[15:0] == 16'd0) ? 16'd1 : i_st_data[15:0];
    end
  end

  // Storage needs no reset: reset clears the pointers, so stale bytes are unreachable
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_st_data[7:0];
  end

  assign w_unused = &{1'b0, i_st_data[31:16], i_lsu_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_io_uart_tx.sv
`default_nettype none
// tb_io_uart_tx : randomized scoreboard bench; a line monitor decodes each
// frame and compares it with the byte queued when the store was issued.
module tb_io_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam logic [31:0] BASE = 32'h0000_7030;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_lsu_addr = 32'd0;
  logic [31:0] i_st_data = 32'd0;
  logic        i_lsu_wren = 1'b0;
  logic        i_lsu_rden = 1'b0;
  logic [31:0] o_ld_data;
  logic        o_sel;
  logic        o_uart_tx;
  logic        o_tx_busy;

  io_uart_tx dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_lsu_addr (i_lsu_addr),
    .i_st_data  (i_st_data),
    .i_lsu_wren (i_lsu_wren),
    .i_lsu_rden (i_lsu_rden),
    .o_ld_data  (o_ld_data),
    .o_sel      (o_sel),
    .o_uart_tx  (o_uart_tx),
    .o_tx_busy  (o_tx_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int exp_div = 434;
  logic [7:0] exp_q[$];
  int         starts[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] off, input logic [31:0] d);
    i_lsu_addr = BASE | {28'd0, off, 2'b00};
    i_st_data  = d;
    i_lsu_wren = 1'b1;
    tick();
    i_lsu_wren = 1'b0;
    if (off == 2'd2) exp_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
  endtask

  task automatic send_byte(input logic [31:0] d);
    write_reg(2'd0, d);
    exp_q.push_back(d[7:0]);
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] d);
    i_lsu_addr = addr;
    i_lsu_rden = 1'b1;
    #1;
    d = o_ld_data;
    i_lsu_rden = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || o_tx_busy) && n < 20000) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Line monitor: checks every bit is steady for the whole period and busy stays high
  initial begin : monitor
    logic        prev;
    logic [10:0] obs, ef;
    logic        ok, abort;
    logic [7:0]  b;
    int          d;
    prev = 1'b1;
    forever begin
      @(negedge i_clk);
      if (!i_rst && prev && !o_uart_tx) begin
        d = exp_div; obs = '0; ok = 1'b1; abort = 1'b0;
        starts.push_back(cyc);
        for (int bi = 0; bi < FB && !abort; bi++) begin
          for (int c = 0; c < d && !abort; c++) begin
            if (!(bi == 0 && c == 0)) @(negedge i_clk);
            if (i_rst) abort = 1'b1;
            else begin
              if (c == 0) obs[bi] = o_uart_tx;
              else if (o_uart_tx !== obs[bi]) ok = 1'b0;
              if (o_tx_busy !== 1'b1) ok = 1'b0;
            end
          end
        end
        if (!abort) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {52'd0, ok, obs}, 64'hFFF);
          end else begin
            b = exp_q.pop_front();
            ef = '0;
            ef[8:1] = b;
            if (FB == 11) ef[9] = ^b;
            ef[FB-1] = 1'b1;
            check("frame", {52'd0, ok, obs}, {52'd0, 1'b1, ef});
          end
        end
      end
      prev = o_uart_tx;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] rd;
    int n, first_tx, gap, len;

    // Reset state and decode
    repeat (3) tick();
    check("rst_tx", 64'(o_uart_tx), 64'd1);
    check("rst_busy", 64'(o_tx_busy), 64'd0);
    i_rst = 1'b0;
    read_reg(BASE | 32'h4, rd); check("rst_status", 64'(rd), 64'h2);
    read_reg(BASE | 32'h8, rd); check("rst_div", 64'(rd), 64'h1B2);
    check("sel_hit", 64'(o_sel), 64'd1);
    read_reg(BASE | 32'h0, rd); check("rd_txdata", 64'(rd), 64'd0);
    read_reg(BASE | 32'hC, rd); check("rd_reserved", 64'(rd), 64'd0);
    read_reg(BASE + 32'h14, rd); check("rd_unsel", 64'(rd), 64'd0);
    check("sel_miss", 64'(o_sel), 64'd0);
    i_lsu_addr = BASE | 32'h4; #1;
    check("no_rden", 64'(o_ld_data), 64'd0);

    // Load and store to DIVISOR in one cycle returns the old value
    i_lsu_addr = BASE | 32'h8; i_st_data = 32'd4;
    i_lsu_wren = 1'b1; i_lsu_rden = 1'b1; #1;
    check("ld_st_same", 64'(o_ld_data), 64'h1B2);
    tick();
    i_lsu_wren = 1'b0; i_lsu_rden = 1'b0; exp_div = 4;
    read_reg(BASE | 32'h8, rd); check("div_4", 64'(rd), 64'd4);

    // Single byte: one-cycle latency, busy for a whole frame
    send_byte(32'h55);
    check("latency_tx", 64'(o_uart_tx), 64'd1);
    check("latency_busy", 64'(o_tx_busy), 64'd0);
    n = 0; first_tx = -1;
    for (int k = 0; k < 500; k++) begin
      tick();
      if (first_tx < 0) first_tx = int'(o_uart_tx);
      if (o_tx_busy) n++;
      else if (n > 0) break;
    end
    check("first_tx_low", 64'(first_tx), 64'd0);
    check("busy_cycles", 64'(n), 64'(FB * 4));
    wait_idle("drain_55");

    // Overflow: ten stores in consecutive cycles, the tenth is dropped
    write_reg(2'd2, 32'd2);
    for (int k = 0; k < 10; k++) begin
      write_reg(2'd0, 32'(k));
      if (k < 9) exp_q.push_back(8'(k));
    end
    read_reg(BASE | 32'h4, rd); check("ovf_status", 64'(rd), 64'h80D);
    write_reg(2'd1, 32'h8);
    read_reg(BASE | 32'h4, rd); check("ovf_clear", 64'(rd), 64'h805);
    wait_idle("drain_ovf");
    read_reg(BASE | 32'h4, rd); check("ovf_empty", 64'(rd), 64'h2);

    // Back-to-back frames with no idle gap
    write_reg(2'd2, 32'd3);
    starts.delete();
    send_byte(32'hA5);
    send_byte(32'h3C);
    wait_idle("drain_b2b");
    check("b2b_frames", 64'(starts.size()), 64'd2);
    if (starts.size() == 2) check("b2b_gap", 64'(starts[1] - starts[0]), 64'(FB * 3));

    // Randomized traffic, bursts small enough never to overflow
    for (int it = 0; it < 12; it++) begin
      write_reg(2'd2, ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 6)));
      read_reg(BASE | 32'h8, rd); check("rnd_div", 64'(rd), 64'(exp_div));
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        send_byte($urandom);
        gap = $urandom_range(0, 3);
        repeat (gap) tick();
      end
      read_reg(BASE | 32'hC, rd); check("rnd_reserved", 64'(rd), 64'd0);
      wait_idle("rnd_drain");
    end

    // Reset in the middle of a data bit with bytes queued
    write_reg(2'd2, 32'd4);
    send_byte(32'h11); send_byte(32'h22); send_byte(32'h33);
    repeat (12) tick();
    check("mid_busy", 64'(o_tx_busy), 64'd1);
    i_rst = 1'b1;
    exp_q.delete();
    tick();
    check("rst_mid_tx", 64'(o_uart_tx), 64'd1);
    check("rst_mid_busy", 64'(o_tx_busy), 64'd0);
    i_rst = 1'b0;
    exp_div = 434;
    read_reg(BASE | 32'h4, rd); check("rst_mid_status", 64'(rd), 64'h2);
    read_reg(BASE | 32'h8, rd); check("rst_mid_div", 64'(rd), 64'h1B2);
    repeat (100) tick();
    check("post_rst_idle", {62'd0, o_tx_busy, o_uart_tx}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped UART transmitter that acts as a responder on the core's load/store (LSU) bus, the target end of the initiator traffic the single-cycle core issues. Stores to its data register push bytes into a small FIFO. A serializer drains the FIFO onto an 8N1 line at a programmable bit period. Loads return status and divisor combinationally, in the same cycle, to suit the single-cycle datapath.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_7030: register window base; the window is 16 bytes and BASE_ADDR[3:0] must be 0.
- FIFO_DEPTH, 8: TX FIFO entries; must be a power of two, ≥2.
- DIV_RESET, 16'd434: reset bit period in clocks (50 MHz / 115200).

Ports:
- i_clk, in, 1: single clock; all state changes on the rising edge.
- i_rst, in, 1: synchronous, active-high reset.
- i_lsu_addr, in, 32: byte address from the core.
- i_st_data, in, 32: store data.
- i_lsu_wren, in, 1: store strobe; committed at the clock edge.
- i_lsu_rden, in, 1: load strobe.
- o_ld_data, out, 32: combinational load data; 0 when not selected or i_lsu_rden=0.
- o_sel, out, 1: combinational; i_lsu_addr[31:4] == BASE_ADDR[31:4].
- o_uart_tx, out, 1: serial line; idles high.
- o_tx_busy, out, 1: high while the FSM is outside IDLE.

## Operation
Register map (offsets use addr[3:2]):
- 0x0 TXDATA, write-only: a write pushes st_data[7:0]. Reads return 0.
- 0x4 STATUS: bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky), bits[11:8] count (zero-extended). Writing 1 to bit3 clears overflow; all other bits are read-only.
- 0x8 DIVISOR: bits[15:0], read/write, upper bits read 0. A write of 0 is stored as 1.
- 0xC: reserved. Reads return 0; writes are ignored.

FIFO push rules:
- A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
- Otherwise the byte is dropped and overflow is set to 1.
- Overflow set and a clearing write in the same cycle: the set wins.

Transmit state machine: IDLE → START → DATA → STOP → (START | IDLE).
- IDLE: o_uart_tx=1. When the FIFO is non-empty, pop the head into the shift register, load the bit counter with DIVISOR−1, and go to START.
- START: o_uart_tx=0 for DIVISOR cycles.
- DATA: 8 bits, LSB first, each DIVISOR cycles; a 3-bit index counts 0..7.
- STOP: o_uart_tx=1 for DIVISOR cycles. At the end, if the FIFO is non-empty, pop and go straight to START (back-to-back frames, no idle gap); else go to IDLE.
- Bit counter: counts down to 0 and reloads from the current DIVISOR at each bit boundary. A DIVISOR write mid-frame therefore takes effect on the next bit only.

## Timing
- Reset values: o_uart_tx=1, o_tx_busy=0, FIFO empty (count=0, pointers 0), overflow=0, DIVISOR=DIV_RESET, state=IDLE. o_ld_data and o_sel are combinational and carry no reset state.
- Reset asserted mid-frame: the line returns high on the next edge and queued bytes are discarded.
- Store at edge N → count increments after N. If IDLE, the pop happens at edge N+1, so o_uart_tx falls and o_tx_busy rises after N+1 (one-cycle latency).
- A frame lasts 10×DIVISOR cycles (11×DIVISOR with parity).
- Load data reflects register state before the current edge. A load and store to the same register in one cycle returns the old value.
- Pointer wrap-around is modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits wide.

## Configuration
- UART_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) is inserted between DATA and STOP via an extra PARITY state held for DIVISOR cycles; the frame is 11 bits.
- Undefined: no PARITY state; 8N1 framing only.

## Test plan
- Reset, then read 0x4 and 0x8 → STATUS=0x0000_0002 (empty); DIVISOR=0x0000_01B2; o_uart_tx=1.
- DIVISOR=4, write 0x55 to TXDATA → line low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4. o_tx_busy is high for 40 cycles.
- DIVISOR=2, 10 back-to-back TXDATA writes in consecutive cycles (bytes 0x00–0x09) → 0x00–0x08 are transmitted, 0x09 is dropped, STATUS bit3=1, and count peaks at 8. Writing 0x8 to STATUS then clears bit3.
- Two queued bytes 0xA5, 0x3C with DIVISOR=3 → the second start bit begins the cycle right after the first stop bit ends; busy never drops between frames.
- Assert i_rst mid-DATA with 3 bytes queued → next edge: o_uart_tx=1, busy=0, STATUS=0x2. No further frames are sent.
- With UART_TX_PARITY_EN and DIVISOR=4, write 0x07 → parity bit 1 is sent for 4 cycles before the stop bit; the frame is 44 cycles.
